// File: rtl/scan_sequencer.sv
// ============================================================================
// scan_sequencer : prescaled 3-bit scan select driving a 3-to-8 decoder.
// Bounce mode is compiled in only when SCAN_SEQ_BOUNCE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] sel,
  output logic       tick,
  output logic       wrap
);

  localparam int c_PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_PRESC_W-1:0] r_presc;
  logic [2:0]           r_sel;
  logic                 r_tick;
  logic                 r_wrap;
  logic [2:0]           w_nxt_sel;
  logic                 w_nxt_wrap;

`ifdef SCAN_SEQ_BOUNCE_EN
  logic r_dir_q;
  logic w_nxt_dq;
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
`endif

  // Next select value for a step; wrap mode follows the live dir input.
  always_comb begin
    w_nxt_sel  = dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
    w_nxt_wrap = dir ? (r_sel == 3'd0) : (r_sel == 3'd7);
`ifdef SCAN_SEQ_BOUNCE_EN
    w_nxt_dq = r_dir_q;
    if (mode) begin
      if (!r_dir_q) begin
        w_nxt_wrap = (r_sel == 3'd7);
        w_nxt_sel  = (r_sel == 3'd7) ? 3'd6 : (r_sel + 3'd1);
        w_nxt_dq   = (r_sel == 3'd7);
      end else begin
        w_nxt_wrap = (r_sel == 3'd0);
        w_nxt_sel  = (r_sel == 3'd0) ? 3'd1 : (r_sel - 3'd1);
        w_nxt_dq   = (r_sel != 3'd0);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_sel   <= 3'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
`ifdef SCAN_SEQ_BOUNCE_EN
      r_dir_q <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (load) begin
        r_sel   <= load_val;
        r_presc <= '0;
`ifdef SCAN_SEQ_BOUNCE_EN
        r_dir_q <= dir;
`endif
      end else if (r_state == IDLE) begin
        r_presc <= '0;
        if (en) begin
          r_state <= RUN;
`ifdef SCAN_SEQ_BOUNCE_EN
          r_dir_q <= dir;
`endif
        end
      end else if (!en) begin
        // Dropping en on a terminal count discards that step.
        r_state <= IDLE;
        r_presc <= '0;
      end else if (r_presc == c_PRESC_MAX) begin
        r_presc <= '0;
        r_sel   <= w_nxt_sel;
        r_tick  <= 1'b1;
        r_wrap  <= w_nxt_wrap;
`ifdef SCAN_SEQ_BOUNCE_EN
        r_dir_q <= w_nxt_dq;
`endif
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign sel  = r_sel;
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// tb_scan_sequencer : three scan_sequencer instances (DIV 4, 1, 3) checked
// every cycle against an edge-counting reference model, plus literal pins.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scan_sequencer;

  localparam int NI = 3;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       en       = 1'b0;
  logic       dir      = 1'b0;
  logic       mode     = 1'b0;
  logic       load     = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] sel_d  [NI];
  logic       tick_d [NI];
  logic       wrap_d [NI];
  logic [7:0] dec_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int div_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 3;
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      scan_sequencer #(.DIV((g == 0) ? 4 : (g == 1) ? 1 : 3)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .sel      (sel_d[g]),
        .tick     (tick_d[g]),
        .wrap     (wrap_d[g])
      );
    end
  endgenerate

  // Downstream 3-to-8 decoder fed by the first instance.
  assign dec_out = 8'b0000_0001 << sel_d[0];

  task automatic check(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: count edges since run start / last step; step on the DIV-th.
  bit         m_run  [NI] = '{default: 1'b0};
  int         m_cnt  [NI] = '{default: 0};
  logic [2:0] m_sel  [NI] = '{default: 3'd0};
  bit         m_dq   [NI] = '{default: 1'b0};
  bit         m_tick [NI] = '{default: 1'b0};
  bit         m_wrap [NI] = '{default: 1'b0};

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NI; k++) begin
      m_tick[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (reset) begin
        m_run[k] = 1'b0;
        m_cnt[k] = 0;
        m_sel[k] = 3'd0;
        m_dq[k]  = 1'b0;
      end else if (load) begin
        m_sel[k] = load_val;
        m_cnt[k] = 0;
        m_dq[k]  = dir;
      end else if (!m_run[k]) begin
        if (en) begin
          m_run[k] = 1'b1;
          m_cnt[k] = 0;
          m_dq[k]  = dir;
        end
      end else if (!en) begin
        m_run[k] = 1'b0;
        m_cnt[k] = 0;
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == div_of(k)) begin
          int s;
          m_cnt[k]  = 0;
          m_tick[k] = 1'b1;
          s = int'(m_sel[k]);
`ifdef SCAN_SEQ_BOUNCE_EN
          if (mode) begin
            if (!m_dq[k]) begin
              if (s == 7) begin s = 6; m_dq[k] = 1'b1; m_wrap[k] = 1'b1; end
              else s = s + 1;
            end else begin
              if (s == 0) begin s = 1; m_dq[k] = 1'b0; m_wrap[k] = 1'b1; end
              else s = s - 1;
            end
          end else
`endif
          begin
            if (dir) begin m_wrap[k] = (s == 0); s = (s + 7) % 8; end
            else     begin m_wrap[k] = (s == 7); s = (s + 1) % 8; end
          end
          m_sel[k] = 3'(s);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      check("sel",  k, 8'(sel_d[k]),  8'(m_sel[k]));
      check("tick", k, 8'(tick_d[k]), 8'(m_tick[k]));
      check("wrap", k, 8'(wrap_d[k]), 8'(m_wrap[k]));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sel", 0, 8'(sel_d[0]), 8'd0);
    check("rst_tick", 0, 8'(tick_d[0]), 8'd0);
    check("rst_dec", 0, dec_out, 8'h01);
    reset = 1'b0;

    // Up/wrap run: first step DIV edges after the edge that samples en.
    @(negedge clk);
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    repeat (4) @(negedge clk);
    check("first_hold", 0, 8'(sel_d[0]), 8'd0);
    @(negedge clk);
    check("first_step", 0, 8'(sel_d[0]), 8'd1);
    check("first_tick", 0, 8'(tick_d[0]), 8'd1);
    check("dec_step", 0, dec_out, 8'h02);
    check("div1_sel", 1, 8'(sel_d[1]), 8'd4);
    check("div3_sel", 2, 8'(sel_d[2]), 8'd1);
    repeat (28) @(negedge clk);
    check("wrap_sel", 0, 8'(sel_d[0]), 8'd0);
    check("wrap_pulse", 0, 8'(wrap_d[0]), 8'd1);
    check("dec_wrap", 0, dec_out, 8'h01);

    // Load coinciding with the terminal count suppresses the step.
    repeat (3) @(negedge clk);
    load = 1'b1; load_val = 3'd5;
    @(negedge clk);
    load = 1'b0;
    check("load_sel", 0, 8'(sel_d[0]), 8'd5);
    check("load_tick", 0, 8'(tick_d[0]), 8'd0);
    repeat (3) @(negedge clk);
    check("post_load_hold", 0, 8'(sel_d[0]), 8'd5);
    @(negedge clk);
    check("post_load_step", 0, 8'(sel_d[0]), 8'd6);
    check("post_load_tick", 0, 8'(tick_d[0]), 8'd1);

    // Async reset pulse between edges, mid-prescale.
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("async_sel", k, 8'(sel_d[k]), 8'd0);
      check("async_tick", k, 8'(tick_d[k]), 8'd0);
    end
    #1 reset = 1'b0;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("rst_rerun_hold", 0, 8'(sel_d[0]), 8'd0);
    @(negedge clk);
    check("rst_rerun_step", 0, 8'(sel_d[0]), 8'd1);

    // Down from 1 with wrap at 0->7, then reverse mid-run.
    @(negedge clk);
    en = 1'b0; load = 1'b1; load_val = 3'd1; dir = 1'b1;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    @(negedge clk);
    check("down_sel0", 1, 8'(sel_d[1]), 8'd0);
    @(negedge clk);
    check("down_sel7", 1, 8'(sel_d[1]), 8'd7);
    check("down_wrap", 1, 8'(wrap_d[1]), 8'd1);
    repeat (10) @(negedge clk);
    dir = 1'b0;
    repeat (12) @(negedge clk);

    // Mode=1 from sel=5 on the DIV=1 instance.
    load = 1'b1; load_val = 3'd5; dir = 1'b0; mode = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("mode1_s6", 1, 8'(sel_d[1]), 8'd6);
    @(negedge clk);
    check("mode1_s7", 1, 8'(sel_d[1]), 8'd7);
    @(negedge clk);
`ifdef SCAN_SEQ_BOUNCE_EN
    check("bounce_s6", 1, 8'(sel_d[1]), 8'd6);
`else
    check("nobounce_s0", 1, 8'(sel_d[1]), 8'd0);
`endif
    check("mode1_wrap", 1, 8'(wrap_d[1]), 8'd1);
    repeat (16) @(negedge clk);

    // Randomized traffic, including occasional async reset pulses.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 15) != 0);
      dir      = ($urandom_range(0, 11) == 0) ? ~dir : dir;
      mode     = ($urandom_range(0, 23) == 0) ? ~mode : mode;
      load     = ($urandom_range(0, 29) == 0);
      load_val = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles per step; legal range 1..256.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port en, input, 1, run enable; stepping SHALL occur only while high.
REQ-005 Port dir, input, 1, requested direction: 0 = up, 1 = down.
REQ-006 Port mode, input, 1, sequence mode: 0 = wrap, 1 = bounce.
REQ-007 Port load, input, 1, synchronous load strobe.
REQ-008 Port load_val, input, 3, value written to sel on load.
REQ-009 Port sel, output, 3, registered select code; drives the 3-to-8 decoder sel input directly.
REQ-010 Port tick, output, 1, registered one-cycle pulse, high in the same cycle a new sel value first appears.
REQ-011 Port wrap, output, 1, registered one-cycle pulse, high with tick when the step crosses an end point.

Function
REQ-012 The FSM SHALL have two states: IDLE and RUN.
REQ-013 Transitions: IDLE->RUN when en=1 and load=0; RUN->IDLE when en=0; load SHALL leave the state unchanged.
REQ-014 The prescaler SHALL be ceil(log2(DIV)) bits wide, minimum 1.
REQ-015 In RUN, presc SHALL count 0..DIV-1; at DIV-1 it returns to 0 and a step occurs on that edge.
REQ-016 In IDLE, presc SHALL be held at 0 and sel SHALL hold its value.
REQ-017 The first step after IDLE->RUN SHALL land exactly DIV rising edges after the first edge sampling en=1.
REQ-018 DIV=1 SHALL step every cycle while in RUN.
REQ-019 On the IDLE->RUN edge, dir_q SHALL capture dir.
REQ-020 Wrap mode: each step SHALL sample dir directly; up gives sel+1 mod 8, down gives sel-1 mod 8.
REQ-021 Wrap mode: wrap SHALL assert on 7->0 (up) and on 0->7 (down).
REQ-022 Bounce mode: steps SHALL follow dir_q.
REQ-023 Bounce mode up: at sel=7, dir_q SHALL flip to down, sel SHALL go to 6, and wrap SHALL assert.
REQ-024 Bounce mode down: at sel=0, dir_q SHALL flip to up, sel SHALL go to 1, and wrap SHALL assert.
REQ-025 tick and wrap SHALL be 0 in every cycle without a step.
REQ-026 Load SHALL have priority over stepping and enable: sel<=load_val, presc<=0, dir_q<=dir, tick=0, wrap=0.
REQ-027 load in the same cycle as a prescaler terminal count SHALL suppress the step.
REQ-028 en falling in the same cycle as a terminal count SHALL suppress the step; the state goes to IDLE.
REQ-029 A mode change SHALL take effect at the next step; it SHALL NOT reset presc.
REQ-030 sel SHALL always be a legal 3-bit value; no X SHALL be present after reset.

Reset
REQ-031 reset=1 SHALL immediately force sel=0, tick=0, wrap=0, presc=0, dir_q=up and state=IDLE, regardless of clk.
REQ-032 Reset asserted mid-count SHALL discard the partial prescale; after release the REQ-017 timing SHALL apply again.
REQ-033 On the first edge after reset deasserts, en, load and the other inputs SHALL be obeyed normally.

Configuration
REQ-034 Macro SCAN_SEQ_BOUNCE_EN SHALL control whether bounce mode is compiled in.
REQ-035 With SCAN_SEQ_BOUNCE_EN defined: bounce mode and the dir_q end-point reversal logic SHALL be present.
REQ-036 With SCAN_SEQ_BOUNCE_EN undefined: mode SHALL be ignored, the block SHALL always behave as wrap mode, and the bounce logic SHALL be absent.

Verification
REQ-037 DIV=4, mode=0, dir=0: reset, then en=1. Required: sel steps 0,1,2,...,7,0 every 4 cycles; first step 4 edges after en; tick with every step; wrap only on 7->0.
REQ-038 DIV=2, mode=0, dir=1, starting from load_val=1: required sel 1,0,7,6 with wrap on 0->7; dir toggled to 0 mid-run reverses at the next step.
REQ-039 Built with SCAN_SEQ_BOUNCE_EN, DIV=1, mode=1, dir=0, from sel=5: required sel 6,7,6,5,...,1,0,1 with wrap at the 7->6 and 0->1 steps; same stimulus without the macro gives 6,7,0,1.
REQ-040 DIV=3: load=1 with load_val=5 on the terminal-count cycle; required sel=5 next cycle, no tick, next step 3 cycles later.
REQ-041 Async reset pulse between clock edges while sel=4 and presc=2: required sel=0 and tick=0 before the next edge; en held high gives sel=1 exactly DIV edges after release.
REQ-042 Decoder-chain check: drive the decoder sel input from this block; required decoder out = 8'b00000001 after reset, then one-hot out advancing one bit per tick.
